// File: rtl/dmem_wait_responder_if.sv
// dmem_wait_responder_if: request/response channels between the core's data port and the responder
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: data-memory responder with LATENCY wait states and one outstanding request
module dmem_wait_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  dmem_wait_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS * 4);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_acc, w_commit, w_we, w_uns, w_err;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_off, w_word, w_ld, w_wrep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [AW-3:0] w_idx;
  // With zero latency the commit happens on the accepting edge, so it must see the live request.
  always_comb begin
    w_acc    = r_state == S_IDLE && bus.req_valid;
    w_commit = (w_acc && LATENCY == 0) || (r_state == S_WAIT && r_cnt == 4'd1);
    w_we     = r_state == S_IDLE ? bus.req_we       : r_we;
    w_addr   = r_state == S_IDLE ? bus.req_addr     : r_addr;
    w_wdata  = r_state == S_IDLE ? bus.req_wdata    : r_wdata;
    w_size   = r_state == S_IDLE ? bus.req_size     : r_size;
    w_uns    = r_state == S_IDLE ? bus.req_unsigned : r_uns;
    w_off    = w_addr - BASE_ADDR;
    w_idx    = w_off[AW-1:2];
    w_err    = w_size == 2'b11 || (w_size == 2'b01 && w_off[0]) ||
               (w_size == 2'b10 && w_off[1:0] != 2'b00) || w_off[31:AW] != '0;
    w_word   = r_mem[w_idx];
    w_byte   = w_word[8*w_off[1:0] +: 8];
    w_half   = w_off[1] ? w_word[31:16] : w_word[15:0];
    w_ld     = w_size == 2'b00 ? {{24{~w_uns & w_byte[7]}}, w_byte} :
               w_size == 2'b01 ? {{16{~w_uns & w_half[15]}}, w_half} : w_word;
    w_be     = w_size == 2'b00 ? 4'b0001 << w_off[1:0] :
               w_size == 2'b01 ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wrep   = w_size == 2'b00 ? {4{w_wdata[7:0]}} :
               w_size == 2'b01 ? {2{w_wdata[15:0]}} : w_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_we && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_cnt   <= 4'(LATENCY);
      end
      if (w_commit) begin
        r_state <= S_RESP;
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : w_ld;
      end else if (w_acc) begin
        r_state <= S_WAIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_state == S_RESP && bus.rsp_ready) begin
        r_state <= S_IDLE;
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
  assign bus.req_ready = r_state == S_IDLE;
  assign bus.rsp_valid = r_state == S_RESP;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = r_state != S_IDLE;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: random and directed traffic checked each cycle against a byte-array memory model
module tb_dmem_wait_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_wait_responder_if ifc();
  dmem_wait_responder_if ifz();
  dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) dz (.clk(clk), .rst_n(rst_n), .bus(ifz));
  int vecs = 0, errs = 0, cyc = 0, acc = 0;
  logic [7:0] mb [1024];
  logic pend = 1'b0, ev, p_we, p_u, e_err, last_err;
  logic [1:0] p_sz;
  logic [31:0] p_a, p_wd, e_rd, last_rd;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Little-endian byte memory; a request is legal only if naturally aligned and inside 1 KiB.
  task automatic model_commit();
    int nb;
    logic [31:0] v;
    nb = 1 << p_sz;
    e_err = p_sz == 2'd3 || (p_sz == 2'd1 && p_a[0]) || (p_sz == 2'd2 && p_a[1:0] != 2'd0) || p_a >= 32'd1024;
    e_rd = 32'd0;
    if (!e_err) begin
      if (p_we) begin
        for (int i = 0; i < nb; i++) mb[p_a + i] = p_wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[p_a + i]) << (8*i));
        if (!p_u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e_rd = v;
      end
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
      chk("rst_rsp_valid", ifc.rsp_valid, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
      chk("rst_rsp_err", ifc.rsp_err, 0);
    end else begin
      if (pend && cyc == acc + 1 + LAT) model_commit();
      ev = pend && cyc >= acc + 1 + LAT;
      chk("req_ready", ifc.req_ready, !pend);
      chk("busy", ifc.busy, pend);
      chk("rsp_valid", ifc.rsp_valid, ev);
      if (ev) begin
        chk("rsp_rdata", ifc.rsp_rdata, e_rd);
        chk("rsp_err", ifc.rsp_err, e_err);
      end
      if (ev && ifc.rsp_ready) begin
        pend = 1'b0;
        last_rd = ifc.rsp_rdata;
        last_err = ifc.rsp_err;
      end else if (!pend && ifc.req_valid) begin
        pend = 1'b1;
        acc = cyc;
        p_we = ifc.req_we;
        p_a = ifc.req_addr;
        p_wd = ifc.req_wdata;
        p_sz = ifc.req_size;
        p_u = ifc.req_unsigned;
      end
    end
  end
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u, input int d);
    int n;
    ifc.req_we = we; ifc.req_addr = a; ifc.req_wdata = wd; ifc.req_size = sz; ifc.req_unsigned = u;
    ifc.req_valid = 1'b1; ifc.rsp_ready = 1'b0;
    n = 0;
    while (!ifc.req_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) begin vecs++; errs++; $display("FAIL accept_timeout: got no req_ready, required within 60 cycles"); end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0; ifc.req_addr = $urandom; ifc.req_wdata = $urandom; ifc.req_we = 1'($urandom);
    n = 0;
    while (!ifc.rsp_valid && n < 60) begin ifc.rsp_ready = 1'($urandom); @(posedge clk); #1; n++; end
    if (n >= 60) begin vecs++; errs++; $display("FAIL rsp_timeout: got no rsp_valid, required within 60 cycles"); end
    ifc.rsp_ready = 1'b0;
    repeat (d) begin
      ifc.req_valid = 1'($urandom); ifc.req_we = 1'($urandom); ifc.req_addr = $urandom & 32'h3FC;
      ifc.req_size = 2'($urandom);
      @(posedge clk); #1;
    end
    ifc.req_valid = 1'b0; ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
  endtask
  task automatic zx(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                    input logic u, input logic [31:0] exp_rd, input logic exp_err, input string n);
    ifz.req_we = we; ifz.req_addr = a; ifz.req_wdata = wd; ifz.req_size = sz; ifz.req_unsigned = u;
    ifz.req_valid = 1'b1;
    @(negedge clk);
    chk({n, "_pre_valid"}, ifz.rsp_valid, 0);
    chk({n, "_pre_ready"}, ifz.req_ready, 1);
    @(posedge clk); #1;
    ifz.req_valid = 1'b0;
    @(negedge clk);
    chk({n, "_valid"}, ifz.rsp_valid, 1);
    chk({n, "_rdata"}, ifz.rsp_rdata, exp_rd);
    chk({n, "_err"}, ifz.rsp_err, exp_err);
    ifz.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifz.rsp_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] a;
    ifc.req_valid = 0; ifc.req_we = 0; ifc.req_addr = 0; ifc.req_wdata = 0; ifc.req_size = 0;
    ifc.req_unsigned = 0; ifc.rsp_ready = 0;
    ifz.req_valid = 0; ifz.req_we = 0; ifz.req_addr = 0; ifz.req_wdata = 0; ifz.req_size = 0;
    ifz.req_unsigned = 0; ifz.rsp_ready = 0;
    foreach (mb[i]) mb[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", ifc.req_ready, 1);
    @(posedge clk); #1;
    xact(1, 32'h10, 32'hDEADBEEF, 2, 0, 0);
    xact(0, 32'h10, 0, 2, 0, 0);
    chk("pin_load_word", last_rd, 32'hDEADBEEF);
    chk("pin_load_word_err", last_err, 0);
    xact(0, 32'h13, 0, 0, 0, 0);
    chk("pin_byte_signed", last_rd, 32'hFFFFFFDE);
    xact(0, 32'h13, 0, 0, 1, 0);
    chk("pin_byte_unsigned", last_rd, 32'h000000DE);
    xact(0, 32'h10, 0, 1, 0, 0);
    chk("pin_half_signed", last_rd, 32'hFFFFBEEF);
    xact(1, 32'h11, 32'h55, 0, 0, 0);
    xact(0, 32'h10, 0, 2, 0, 0);
    chk("pin_partial_store", last_rd, 32'hDEAD55EF);
    xact(0, 32'h11, 0, 1, 0, 0);
    chk("pin_misaligned_err", last_err, 1);
    chk("pin_misaligned_rdata", last_rd, 0);
    xact(1, 32'h0, 32'h0BADF00D, 2, 0, 0);
    xact(1, 32'h400, 32'hFFFFFFFF, 2, 0, 0);
    chk("pin_range_err", last_err, 1);
    xact(0, 32'h0, 0, 2, 0, 0);
    chk("pin_word0_intact", last_rd, 32'h0BADF00D);
    xact(0, 32'h4, 0, 3, 0, 0);
    chk("pin_size11_err", last_err, 1);
    xact(0, 32'h10, 0, 2, 0, 5);
    chk("pin_backpressure", last_rd, 32'hDEAD55EF);
    xact(1, 32'h20, 32'h11111111, 2, 0, 0);
    ifc.req_we = 1; ifc.req_addr = 32'h20; ifc.req_wdata = 32'h12345678; ifc.req_size = 2; ifc.req_valid = 1;
    @(posedge clk); #1;
    ifc.req_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", ifc.busy, 0);
    chk("post_reset_rsp_valid", ifc.rsp_valid, 0);
    @(posedge clk); #1;
    xact(0, 32'h20, 0, 2, 0, 0);
    chk("pin_reset_drops_store", last_rd, 32'h11111111);
    for (int i = 0; i < 256; i++) xact(1, 32'(i * 4), $urandom, 2, 0, 0);
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 1039));
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      xact(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    zx(1, 32'h8, 32'hA5A5_C3A5, 2, 0, 32'h0, 0, "z_store");
    zx(0, 32'h8, 0, 2, 0, 32'hA5A5_C3A5, 0, "z_load_word");
    zx(0, 32'h9, 0, 0, 0, 32'hFFFF_FFC3, 0, "z_load_byte");
    zx(0, 32'hA, 0, 1, 1, 32'h0000_A5A5, 0, "z_load_half");
    zx(0, 32'h8, 0, 3, 0, 32'h0, 1, "z_size11");
    @(negedge clk);
    chk("z_idle_after", ifz.req_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
